// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes stage: LANES bytes per cycle through LANES
// inverse S-box lanes, MSB byte group first. valid/ready on both sides.
// Optional macro INV_SBOX_REG_EN registers each lane's S-box output, so
// every lookup is written back one cycle later (latency NSTEP+1).

// Single-lane FIPS-197 inverse S-box: combinational ROM, row chosen by the
// high nibble, column byte picked out of the row constant by the low nibble.
module inv_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    logic [127:0] row;
    logic [6:0]   msb;

    // Row lookup then column select (column c sits at bits 127-8c .. 120-8c)
    always_comb begin
        row = '0;
        case (din[7:4])
            4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
            4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
            4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
            4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
            4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
            4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
            4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
            4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
            4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
            4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
            4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
            4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
            4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
            4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
            4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
            default: row = 128'h172b047eba77d626e169146355210c7d;
        endcase
        msb  = {~din[3:0], 3'b111};
        dout = row[msb -: 8];
    end
endmodule

module inv_sub_bytes_iter #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    localparam int NSTEP = 16 / LANES;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nxt;

    // Buffer viewed as NSTEP groups of LANES bytes; group NSTEP-1 holds
    // bytes 15..16-LANES, so counting cnt up walks MSB group first.
    logic [NSTEP-1:0][LANES-1:0][7:0] buffer;
    logic [CW-1:0]                    cnt;
    logic [CW-1:0]                    grp;
    logic [LANES-1:0][7:0]            lane_in;
    logic [LANES-1:0][7:0]            lane_out;

`ifdef INV_SBOX_REG_EN
    logic [LANES-1:0][7:0] sbox_q;
    logic [CW-1:0]         grp_q;
    logic                  wb_pend;
    logic                  lk_done;
`endif

    assign grp     = LAST - cnt;
    assign lane_in = buffer[grp];

    genvar l;
    generate
        for (l = 0; l < LANES; l++) begin : g_lane
            inv_sbox u_sbox (.din(lane_in[l]), .dout(lane_out[l]));
        end
    endgenerate

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_state = buffer;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: accept in IDLE, finish after last write-back, drain on ready
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = RUN;
`ifdef INV_SBOX_REG_EN
            RUN:  if (lk_done) state_nxt = DONE;
`else
            RUN:  if (cnt == LAST) state_nxt = DONE;
`endif
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load on accept, substitute one byte group per step
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buffer  <= '0;
            cnt     <= '0;
`ifdef INV_SBOX_REG_EN
            sbox_q  <= '0;
            grp_q   <= '0;
            wb_pend <= 1'b0;
            lk_done <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        buffer  <= in_state;
                        cnt     <= '0;
`ifdef INV_SBOX_REG_EN
                        wb_pend <= 1'b0;
                        lk_done <= 1'b0;
`endif
                    end
                end
                RUN: begin
`ifdef INV_SBOX_REG_EN
                    // Lookup for step k lands in sbox_q, written back at k+1;
                    // groups differ, so the read of k+1 never sees stale data.
                    if (!lk_done) begin
                        sbox_q <= lane_out;
                        grp_q  <= grp;
                        if (cnt == LAST) lk_done <= 1'b1;
                        else             cnt     <= cnt + CW'(1);
                    end
                    wb_pend <= !lk_done;
                    if (wb_pend) buffer[grp_q] <= sbox_q;
`else
                    buffer[grp] <= lane_out;
                    cnt         <= cnt + CW'(1);
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Directed bench for inv_sub_bytes_iter: LANES=4 main instance plus
// LANES=1 and LANES=16 instances for the latency sweep.
module tb_inv_sub_bytes_iter;
`ifdef INV_SBOX_REG_EN
    localparam int X = 1;
`else
    localparam int X = 0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_state;
    int           sel;
    int           checks = 0;
    int           errors = 0;

    logic         iv4, iv1, iv16;
    logic         ir4, ir1, ir16, ov4, ov1, ov16, bz4, bz1, bz16;
    logic [127:0] os4, os1, os16;
    logic         ir_s, ov_s, bz_s;
    logic [127:0] os_s;

    localparam logic [127:0] ALL52 = {16{8'h52}};
    localparam logic [127:0] ALL63 = {16{8'h63}};
    localparam logic [127:0] V3_IN = 128'h637CFF01_00000000_00000000_00000000;
    localparam logic [127:0] V3_EX = 128'h00017D09_52525252_52525252_52525252;

    always #5 clk = ~clk;

    assign iv4  = in_valid & (sel == 0);
    assign iv1  = in_valid & (sel == 1);
    assign iv16 = in_valid & (sel == 2);

    inv_sub_bytes_iter #(.LANES(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir4), .in_state(in_state),
        .out_valid(ov4), .out_ready(out_ready), .out_state(os4), .busy(bz4));
    inv_sub_bytes_iter #(.LANES(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .in_state(in_state),
        .out_valid(ov1), .out_ready(out_ready), .out_state(os1), .busy(bz1));
    inv_sub_bytes_iter #(.LANES(16)) u_dut16 (
        .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16), .in_state(in_state),
        .out_valid(ov16), .out_ready(out_ready), .out_state(os16), .busy(bz16));

    // Route the selected instance's outputs to one set of observation signals
    always_comb begin
        case (sel)
            1:       begin ir_s = ir1;  ov_s = ov1;  bz_s = bz1;  os_s = os1;  end
            2:       begin ir_s = ir16; ov_s = ov16; bz_s = bz16; os_s = os16; end
            default: begin ir_s = ir4;  ov_s = ov4;  bz_s = bz4;  os_s = os4;  end
        endcase
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one state, then measure cycles from accept edge to out_valid
    task automatic run_vec(input string tag, input int s, input logic [127:0] st,
                           input logic [127:0] exp, input int lat);
        int n;
        sel      = s;
        in_state = st;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_state = '1;
        chk({tag, "_in_ready_low"}, 128'(ir_s), 128'(0));
        chk({tag, "_busy"}, 128'(bz_s), 128'(1));
        n = 0;
        while (!ov_s && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, 128'(n), 128'(lat));
        chk({tag, "_out_state"}, os_s, exp);
    endtask

    // One edge with out_ready high: handshake completes, back to IDLE
    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_idle_ready"}, 128'(ir_s), 128'(1));
        chk({tag, "_idle_valid"}, 128'(ov_s), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_valid;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_state  = '0;
        sel       = 0;
        #12;
        chk("rst_out_valid", 128'(ov4), 128'(0));
        chk("rst_in_ready", 128'(ir4), 128'(1));
        chk("rst_busy", 128'(bz4), 128'(0));
        chk("rst_out_state", os4, 128'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        run_vec("t1_zero", 0, 128'h0, ALL52, 4 + X);
        drain("t1");
        run_vec("t2_all63", 0, ALL63, 128'h0, 4 + X);
        drain("t2");
        run_vec("t3_order", 0, V3_IN, V3_EX, 4 + X);
        drain("t3");

        // Backpressure: output held, new input ignored while DONE
        out_ready = 1'b0;
        run_vec("t4_stall", 0, ALL63, 128'h0, 4 + X);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_state = 128'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C;
            @(posedge clk); #1;
            chk("t4_hold_valid", 128'(ov4), 128'(1));
            chk("t4_hold_state", os4, 128'h0);
            chk("t4_hold_in_ready", 128'(ir4), 128'(0));
        end
        in_valid = 1'b0;
        drain("t4");
        chk("t4_state_kept", os4, 128'h0);

        // Reset mid-RUN: immediate idle, aborted state never emitted
        in_state = ALL63;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("t5_rst_valid", 128'(ov4), 128'(0));
        chk("t5_rst_ready", 128'(ir4), 128'(1));
        chk("t5_rst_busy", 128'(bz4), 128'(0));
        chk("t5_rst_state", os4, 128'h0);
        #2;
        reset = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ov4) saw_valid = 1'b1;
        end
        chk("t5_no_emit", 128'(saw_valid), 128'(0));
        run_vec("t5_after", 0, V3_IN, V3_EX, 4 + X);
        drain("t5");

        // Lane-count sweep
        run_vec("t6_l1", 1, V3_IN, V3_EX, 16 + X);
        drain("t6_l1");
        run_vec("t6_l16", 2, V3_IN, V3_EX, 1 + X);
        drain("t6_l16");
        run_vec("t6_l16_zero", 2, 128'h0, ALL52, 1 + X);
        drain("t6_l16b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
